// File: rtl/alusrcb_pipe_sel.sv
// Pipelined ALU source-B selector: picks a packed source or CONST_VAL, optional <<2, 2-entry skid output.
// Optional build macro ALUSRCB_SEL_CHECK_EN: out-of-range sel yields 0 and raises sticky sel_err.
module alusrcb_pipe_sel #(
    parameter int          DATA_W    = 32,
    parameter int          NUM_SRC   = 4,
    parameter int          SEL_W     = 2,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_W*(NUM_SRC-1)-1:0]   src_bus,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            shl2,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            sel_err
);

    localparam logic [DATA_W-1:0] CONST_W = DATA_W'(CONST_VAL);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_reg, skid_reg;
    logic [DATA_W-1:0]   slice [NUM_SRC-1];
    logic [DATA_W-1:0]   sel_value, operand;
    logic                in_fire, out_fire;
    logic                main_load, main_from_skid, skid_load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC - 1; gi++) begin : g_slice
            assign slice[gi] = src_bus[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef ALUSRCB_SEL_CHECK_EN
    logic sel_oor;
    logic sel_err_reg;
`endif

    always_comb begin
        sel_value = CONST_W;
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_value = slice[k];
            end
        end
`ifdef ALUSRCB_SEL_CHECK_EN
        sel_oor = (int'(sel) > NUM_SRC - 1);
        if (sel_oor) begin
            sel_value = '0;
        end
`endif
        operand = shl2 ? (sel_value << 2) : sel_value;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register: occupancy of the main/skid pair
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_EMPTY: if (in_fire) state_next = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_next = ST_FULL;
                else if (!in_fire && out_fire) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Handshake flags decode from the registered state only, never from out_ready
    always_comb begin
        in_ready       = 1'b1;
        out_valid      = 1'b0;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_reg)
            ST_EMPTY: main_load = in_fire;
            ST_ONE: begin
                out_valid = 1'b1;
                main_load = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
            end
            ST_FULL: begin
                in_ready       = 1'b0;
                out_valid      = 1'b1;
                main_from_skid = out_fire;
            end
            default: in_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (main_load) begin
                main_reg <= operand;
            end else if (main_from_skid) begin
                main_reg <= skid_reg;
            end
            if (skid_load) begin
                skid_reg <= operand;
            end
        end
    end

    assign out_data = main_reg;

`ifdef ALUSRCB_SEL_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_reg <= 1'b0;
        end else if (in_fire && sel_oor) begin
            sel_err_reg <= 1'b1;
        end
    end
    assign sel_err = sel_err_reg;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_alusrcb_pipe_sel.sv
// Randomized + directed bench for alusrcb_pipe_sel (default build and NUM_SRC=3 build side by side).
module tb_alusrcb_pipe_sel;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [95:0] src_bus = '0;
    logic [1:0]  sel = '0;
    logic        shl2 = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, sel_err;
    logic [31:0] out_data;
    logic        in_ready3, out_valid3, sel_err3;
    logic [31:0] out_data3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [31:0] q3[$];
    bit          err3_model = 1'b0;

    always #5 clk = ~clk;

    alusrcb_pipe_sel dut (
        .clk(clk), .reset_n(reset_n), .src_bus(src_bus), .sel(sel), .shl2(shl2),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
    );

    alusrcb_pipe_sel #(.NUM_SRC(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .src_bus(src_bus[63:0]), .sel(sel), .shl2(shl2),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready), .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference operand: plain arithmetic over the source list
    function automatic logic [31:0] ref_val(input logic [95:0] src, input int s, input bit sh,
                                            input int nsrc);
        logic [95:0]     shifted;
        longint unsigned v;
        if (s < nsrc - 1) begin
            shifted = src >> (32 * s);
            v = longint'(shifted[31:0]);
        end else if (s == nsrc - 1) begin
            v = 4;
        end else begin
`ifdef ALUSRCB_SEL_CHECK_EN
            v = 0;
`else
            v = 4;
`endif
        end
        if (sh) v = (v * 4) % (64'd1 << 32);
        return v[31:0];
    endfunction

    // Called at a negedge: check outputs against the model, present inputs, advance one cycle
    task automatic step(input bit v, input logic [1:0] s, input bit sh, input logic [95:0] src,
                        input bit rdy);
        bit inf, outf, inf3, outf3;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0]));
        chk("sel_err", 64'(sel_err), 64'(0));
        chk("out_valid3", 64'(out_valid3), 64'(q3.size() > 0));
        chk("in_ready3", 64'(in_ready3), 64'(q3.size() < 2));
        if (q3.size() > 0) chk("out_data3", 64'(out_data3), 64'(q3[0]));
        chk("sel_err3", 64'(sel_err3), 64'(err3_model));

        in_valid  = v;
        sel       = s;
        shl2      = sh;
        src_bus   = src;
        out_ready = rdy;

        inf   = v && (q.size() < 2);
        outf  = rdy && (q.size() > 0);
        inf3  = v && (q3.size() < 2);
        outf3 = rdy && (q3.size() > 0);
        if (outf)  void'(q.pop_front());
        if (inf)   q.push_back(ref_val(src, int'(s), sh, 4));
        if (outf3) void'(q3.pop_front());
        if (inf3)  q3.push_back(ref_val(src, int'(s), sh, 3));
`ifdef ALUSRCB_SEL_CHECK_EN
        if (inf3 && s > 2'd2) err3_model = 1'b1;
`endif
        $display("step v=%0b sel=%0d shl2=%0b rdy=%0b src=%h occ=%0d occ3=%0d",
                 v, s, sh, rdy, src, q.size(), q3.size());
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle with in_valid held high; returns at a negedge with reset released
    task automatic async_reset();
        in_valid  = 1'b1;
        sel       = 2'd0;
        src_bus   = 96'h5A5A;
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid3", 64'(out_valid3), 64'(0));
        chk("rst_sel_err3", 64'(sel_err3), 64'(0));
        q.delete();
        q3.delete();
        err3_model = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_hold_valid", 64'(out_valid), 64'(0));
            chk("rst_hold_data", 64'(out_data), 64'(0));
        end
        reset_n = 1'b1;
        $display("reset released at t=%0t", $time);
    endtask

    localparam logic [95:0] SWEEP = {32'h33, 32'h22, 32'h11};

    initial begin
        @(negedge clk);
        async_reset();
        step(1, 2'd0, 0, 96'h10, 1);
        step(0, 2'd0, 0, '0, 1);

        for (int s = 0; s < 4; s++) step(1, 2'(s), 0, SWEEP, 1);
        step(0, 2'd0, 0, '0, 1);

        step(1, 2'd2, 1, {32'hC000_0003, 32'h0, 32'h0}, 1);
        step(1, 2'd3, 1, '0, 1);
        step(1, 2'd1, 0, SWEEP, 1);
        step(0, 2'd0, 0, '0, 1);

        step(1, 2'd0, 0, 96'h1, 0);
        step(1, 2'd0, 0, 96'h2, 0);
        step(1, 2'd0, 0, 96'h3, 0);
        step(1, 2'd0, 0, 96'h3, 0);
        step(1, 2'd0, 0, 96'h3, 1);
        step(1, 2'd0, 0, 96'h3, 1);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, '0, 1);

        step(1, 2'd0, 0, 96'hAA, 0);
        step(1, 2'd0, 0, 96'hBB, 0);
        async_reset();
        step(1, 2'd1, 0, {32'h0, 32'h77, 32'h0}, 1);
        step(0, 2'd0, 0, '0, 1);

        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom}, bit'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, '0, 1);
        step(0, 2'd0, 0, '0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
